// File: rtl/cpu_req_arbiter.sv
// Round-robin arbiter sharing the CPU request FIFO between NUM_REQ requesters,
// with an in-order tag queue that steers returned burst words back to their owner.
module cpu_req_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_WORDS  = 8,
    parameter int TAG_DEPTH  = 4,
    parameter int LEN_W      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         req_fifo_data_in,
    output logic                          req_fifo_enq,
    input  logic                          req_fifo_wrfull,
    input  logic [DATA_WIDTH-1:0]         read_fifo_data_out,
    output logic                          read_fifo_deq,
    input  logic                          read_fifo_rdempty,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_last,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [$clog2(TAG_DEPTH):0]    outstanding,
    output logic                          err_orphan
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    // Handshake: a word moves only in a cycle where valid and ready are both 1;
    // valid never depends on ready, ready may depend on valid (combinational grant).

    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       tag_id  [TAG_DEPTH];
    logic [LEN_W-1:0]      tag_len [TAG_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]      occ;
    logic [LEN_W-1:0]      beat_cnt;

    logic [DATA_WIDTH-1:0] req_word [NUM_REQ];
    logic [ID_W:0]         cand;
    logic                  found;
    logic [ID_W-1:0]       win;
    logic [DATA_WIDTH-1:0] win_word;
    logic [LEN_W-1:0]      raw_len;
    logic [LEN_W-1:0]      win_len;
    logic                  tag_full;
    logic                  tag_empty;
    logic                  can_issue;
    logic                  push;
    logic                  pop;
    logic [ID_W-1:0]       hid;
    logic [LEN_W-1:0]      hlen;
    logic                  head_valid;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
        assign req_word[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign tag_full  = (occ == OCC_W'(TAG_DEPTH));
    assign tag_empty = (occ == '0);
    assign can_issue = !rst && !req_fifo_wrfull && !tag_full;

    // Search starts at rr_ptr and wraps modulo NUM_REQ.
    always_comb begin
        cand     = '0;
        found    = 1'b0;
        win      = '0;
        win_word = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found    = 1'b1;
                win      = cand[ID_W-1:0];
                win_word = req_word[cand[ID_W-1:0]];
            end
        end
    end

    assign raw_len = win_word[DATA_WIDTH-1 -: LEN_W];

    always_comb begin
        win_len = raw_len;
        if (raw_len == '0)                    win_len = LEN_W'(1);
        else if (raw_len > LEN_W'(MAX_WORDS)) win_len = LEN_W'(MAX_WORDS);
    end

    assign push = can_issue && found;

    always_comb begin
        req_ready = '0;
        if (push) req_ready[win] = 1'b1;
    end

    assign req_fifo_enq     = push;
    assign req_fifo_data_in = win_word;

    assign hid        = tag_id[rd_ptr];
    assign hlen       = tag_len[rd_ptr];
    assign head_valid = !rst && !tag_empty && !read_fifo_rdempty;

    always_comb begin
        rsp_valid = '0;
        if (head_valid) rsp_valid[hid] = 1'b1;
    end

    assign rsp_last      = head_valid && (beat_cnt == hlen - LEN_W'(1));
    assign read_fifo_deq = head_valid && rsp_ready[hid];
    assign pop           = read_fifo_deq && rsp_last;
    assign rsp_data      = read_fifo_data_out;
    assign outstanding   = occ;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            beat_cnt   <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (push) begin
                tag_id[wr_ptr]  <= win;
                tag_len[wr_ptr] <= win_len;
                wr_ptr          <= wr_ptr + PTR_W'(1);
                rr_ptr          <= (win == ID_W'(NUM_REQ-1)) ? '0 : win + ID_W'(1);
            end
            if (read_fifo_deq) beat_cnt <= rsp_last ? '0 : beat_cnt + LEN_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            // Data with nothing outstanding can't be steered; it stays in the FIFO.
            if (tag_empty && !read_fifo_rdempty) err_orphan <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cpu_req_arbiter.sv
// Bench for cpu_req_arbiter: directed steps plus a random phase, checked against
// a model that expands each grant into its list of expected result beats.
module tb_cpu_req_arbiter;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int MW = 8;
  localparam int TD = 4;
  localparam int LW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic [DW-1:0]    req_fifo_data_in;
  logic             req_fifo_enq;
  logic             req_fifo_wrfull;
  logic [DW-1:0]    read_fifo_data_out;
  logic             read_fifo_deq;
  logic             read_fifo_rdempty;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic             rsp_last;
  logic [NR-1:0]    rsp_ready;
  logic [2:0]       outstanding;
  logic             err_orphan;

  logic [DW-1:0] words [NR];
  logic [DW-1:0] rd_q[$];
  logic [4:0]    exp_q[$];
  int            win_log[$];
  int            dlv_cnt [NR];
  int            total = 0;
  int            bad = 0;
  int            owed = 0;
  int            m_rr = 0;
  bit            m_err = 0;
  bit            auto_feed = 0;
  int            feed_pct = 100;
  int            n_before;

  always #5 clk = ~clk;

  assign req_data = {words[3], words[2], words[1], words[0]};

  cpu_req_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_WORDS(MW), .TAG_DEPTH(TD), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .req_fifo_data_in(req_fifo_data_in), .req_fifo_enq(req_fifo_enq), .req_fifo_wrfull(req_fifo_wrfull),
    .read_fifo_data_out(read_fifo_data_out), .read_fifo_deq(read_fifo_deq), .read_fifo_rdempty(read_fifo_rdempty),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_ready(rsp_ready),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requests not yet fully delivered = number of final beats still expected.
  function automatic int model_occ();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i][4]) n++;
    return n;
  endfunction

  function automatic int clamp_len(input logic [DW-1:0] w);
    int raw = int'(w[DW-1 -: LW]);
    if (raw == 0) return 1;
    if (raw > MW) return MW;
    return raw;
  endfunction

  task automatic tick();
    logic [NR-1:0] e_ready, e_rv;
    logic          e_last, e_deq;
    logic [DW-1:0] e_data;
    int            win, occ, hid, len;
    if (auto_feed && owed > 0 && $urandom_range(0, 99) < feed_pct) begin
      rd_q.push_back($urandom());
      owed--;
    end
    read_fifo_rdempty  = (rd_q.size() == 0);
    read_fifo_data_out = (rd_q.size() != 0) ? rd_q[0] : '0;
    #1;
    occ = model_occ();
    win = -1;
    e_ready = '0; e_data = '0;
    if (!rst && !req_fifo_wrfull && occ < TD)
      for (int k = 0; k < NR; k++)
        if (win < 0 && req_valid[2'((m_rr + k) % NR)]) win = (m_rr + k) % NR;
    if (win >= 0) begin
      e_ready[2'(win)] = 1'b1;
      e_data = words[2'(win)];
    end
    e_rv = '0; e_last = 1'b0; e_deq = 1'b0; hid = 0;
    if (!rst && exp_q.size() != 0 && rd_q.size() != 0) begin
      hid = int'(exp_q[0][3:0]);
      e_rv[2'(hid)] = 1'b1;
      e_last = exp_q[0][4];
      e_deq = rsp_ready[2'(hid)];
    end
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    chk("req_fifo_enq", 64'(req_fifo_enq), 64'(win >= 0));
    if (win >= 0) chk("req_fifo_data_in", 64'(req_fifo_data_in), 64'(e_data));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
    chk("read_fifo_deq", 64'(read_fifo_deq), 64'(e_deq));
    if (rst || e_rv != 0) chk("rsp_last", 64'(rsp_last), 64'(e_last));
    if (e_rv != 0) chk("rsp_data", 64'(rsp_data), 64'(rd_q[0]));
    if (!rst) begin
      chk("outstanding", 64'(outstanding), 64'(occ));
      chk("err_orphan", 64'(err_orphan), 64'(m_err));
    end
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete(); rd_q.delete();
      owed = 0; m_rr = 0; m_err = 0;
    end else begin
      if (exp_q.size() == 0 && rd_q.size() != 0) m_err = 1;
      if (e_deq) begin
        void'(exp_q.pop_front());
        void'(rd_q.pop_front());
        dlv_cnt[hid]++;
      end
      if (win >= 0) begin
        len = clamp_len(e_data);
        for (int b = 1; b <= len; b++) exp_q.push_back({(b == len), 4'(win)});
        owed += len;
        m_rr = (win + 1) % NR;
        win_log.push_back(win);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    win_log.delete();
    foreach (dlv_cnt[i]) dlv_cnt[i] = 0;
  endtask

  task automatic drain();
    req_valid = '0; req_fifo_wrfull = 1'b0; rsp_ready = '1;
    auto_feed = 1; feed_pct = 100;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    chk("drain_outstanding", 64'(outstanding), 64'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_fifo_wrfull = 1'b0; rsp_ready = '0;
    read_fifo_rdempty = 1'b1; read_fifo_data_out = '0;
    foreach (words[i]) words[i] = '0;
    foreach (dlv_cnt[i]) dlv_cnt[i] = 0;

    // reset state
    do_reset();
    do_reset();
    chk("reset_outstanding", 64'(outstanding), 64'd0);
    chk("reset_err", 64'(err_orphan), 64'd0);

    // single request, burst of three
    words[0] = 32'h3000_0010; req_valid = 4'b0001;
    tick();
    req_valid = '0; owed = 0;
    chk("single_outstanding", 64'(outstanding), 64'd1);
    rd_q.push_back(32'hA); rd_q.push_back(32'hB); rd_q.push_back(32'hC);
    rsp_ready = 4'b0001;
    repeat (3) tick();
    chk("single_delivered", 64'(dlv_cnt[0]), 64'd3);
    chk("single_done", 64'(outstanding), 64'd0);

    // round-robin fairness
    do_reset();
    for (int i = 0; i < NR; i++) words[i] = 32'h1000_0000 | i;
    req_valid = 4'b1111; rsp_ready = '1; auto_feed = 1; feed_pct = 100;
    repeat (8) tick();
    chk("rr_count", 64'(win_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < win_log.size(); i++) chk("rr_order", 64'(win_log[i]), 64'(i % NR));
    drain();

    // request FIFO full backpressure
    do_reset();
    words[1] = 32'h1000_0111; words[2] = 32'h1000_0222;
    req_valid = 4'b0110; req_fifo_wrfull = 1'b1;
    repeat (5) tick();
    chk("wrfull_no_grant", 64'(win_log.size()), 64'd0);
    req_fifo_wrfull = 1'b0;
    tick();
    chk("wrfull_first_grant", 64'(win_log.size() != 0 ? win_log[0] : -1), 64'd1);
    drain();

    // tag queue full
    auto_feed = 0; rsp_ready = '0;
    for (int i = 0; i < NR; i++) words[i] = 32'h2000_0000 | $urandom_range(0, 16'hffff);
    req_valid = 4'b1111;
    repeat (4) tick();
    chk("tag_full_outstanding", 64'(outstanding), 64'd4);
    n_before = win_log.size();
    repeat (2) tick();
    chk("tag_full_stall", 64'(win_log.size()), 64'(n_before));
    chk("tag_full_ready", 64'(req_ready), 64'd0);
    auto_feed = 1; rsp_ready = '1;
    repeat (6) tick();
    drain();

    // response stall and steering
    do_reset();
    auto_feed = 0;
    words[2] = 32'h2000_0002; req_valid = 4'b0100; tick();
    words[0] = 32'h1000_0000; req_valid = 4'b0001; tick();
    req_valid = '0; owed = 0;
    rd_q.push_back($urandom()); rd_q.push_back($urandom()); rd_q.push_back($urandom());
    rsp_ready = 4'b0001;
    repeat (3) tick();
    chk("stall_no_deq", 64'(dlv_cnt[0] + dlv_cnt[2]), 64'd0);
    rsp_ready = 4'b0100; repeat (2) tick();
    rsp_ready = 4'b0001; tick();
    chk("steer_id2", 64'(dlv_cnt[2]), 64'd2);
    chk("steer_id0", 64'(dlv_cnt[0]), 64'd1);

    // length clamp
    do_reset();
    words[0] = 32'h0ABC_DEF0; req_valid = 4'b0001; tick();
    words[1] = 32'hF123_4567; req_valid = 4'b0010; tick();
    drain();
    chk("clamp_len0", 64'(dlv_cnt[0]), 64'd1);
    chk("clamp_len15", 64'(dlv_cnt[1]), 64'd8);

    // orphan data
    do_reset();
    auto_feed = 0; rsp_ready = '1;
    rd_q.push_back(32'hDEAD_BEEF);
    tick();
    chk("orphan_flag", 64'(err_orphan), 64'd1);
    chk("orphan_no_deq", 64'(read_fifo_deq), 64'd0);
    tick();

    // reset mid-burst
    rd_q.delete();
    words[0] = 32'h4000_0000; req_valid = 4'b0001; tick();
    req_valid = '0; owed = 0;
    rd_q.push_back($urandom()); rd_q.push_back($urandom());
    repeat (2) tick();
    chk("midburst_outstanding", 64'(outstanding), 64'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    read_fifo_rdempty = 1'b1;
    #1;
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_err", 64'(err_orphan), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_deq", 64'(read_fifo_deq), 64'd0);
    chk("rst_enq", 64'(req_fifo_enq), 64'd0);

    // random traffic
    do_reset();
    auto_feed = 1; feed_pct = 60;
    for (int c = 0; c < 400; c++) begin
      req_valid = NR'($urandom());
      for (int i = 0; i < NR; i++) words[i] = $urandom();
      req_fifo_wrfull = ($urandom_range(0, 3) == 0);
      rsp_ready = NR'($urandom());
      tick();
    end
    drain();
    chk("random_no_orphan", 64'(err_orphan), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_req_arbiter.md
Name: cpu_req_arbiter

Overview:
- Round-robin arbiter that shares the CPU request FIFO between NUM_REQ requesters.
- Each request word asks the CPU for a burst of 1..MAX_WORDS result words.
- The arbiter forwards the winning request word into the request FIFO and records the requester ID and burst length in an internal in-order tag queue.
- It pops result words from the read FIFO and steers each one back to the requester at the head of the tag queue.
- It sits between the requester agents and the cpu_rmc request/read FIFO pair.

Parameters:
- DATA_WIDTH, 32, width of request and result words; equals CPU_DATA_WIDTH.
- NUM_REQ, 4, number of requesters; range 2..8.
- MAX_WORDS, 8, maximum result words per request.
- TAG_DEPTH, 4, number of outstanding requests tracked; must be a power of 2.
- LEN_W, 4, width of the length field in bits [DATA_WIDTH-1 -: LEN_W]; must be at least clog2(MAX_WORDS)+1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a request word pending.
- req_data  in  NUM_REQ*DATA_WIDTH  request words; slice i = [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot grant; the request is accepted in a cycle where req_valid[i] and req_ready[i] are both 1.
- req_fifo_data_in  out  DATA_WIDTH  winning request word, passed through unmodified.
- req_fifo_enq  out  1  push into the request FIFO.
- req_fifo_wrfull  in  1  request FIFO full.
- read_fifo_data_out  in  DATA_WIDTH  show-ahead head word of the read FIFO.
- read_fifo_deq  out  1  pop the read FIFO.
- read_fifo_rdempty  in  1  read FIFO empty.
- rsp_valid  out  NUM_REQ  one-hot result-word valid, per requester.
- rsp_data  out  DATA_WIDTH  result word, equal to read_fifo_data_out.
- rsp_last  out  1  current word is the final word of its burst.
- rsp_ready  in  NUM_REQ  requester i accepts the word.
- outstanding  out  clog2(TAG_DEPTH)+1  number of tag-queue entries.
- err_orphan  out  1  sticky flag: read FIFO had data while the tag queue was empty.

Behaviour:
- Reset (rst=1 at a clock edge) clears:
  - rr_ptr to 0;
  - tag-queue read/write pointers and occupancy to 0;
  - beat counter to 0;
  - err_orphan to 0.
- Resulting outputs after reset: req_ready=0, req_fifo_enq=0, read_fifo_deq=0, rsp_valid=0, rsp_last=0, outstanding=0.
- While rst=1, all handshake outputs are held at 0.
- Reset mid-burst drops all tracking. The external FIFOs are not flushed by this block; the system resets them together with it.
- Issue side (combinational grant, registered pointer, zero latency):
  - can_issue = !req_fifo_wrfull && tag queue not full.
  - If can_issue, grant the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready = one-hot grant; req_fifo_enq = |grant; req_fifo_data_in = req_data slice of the winner.
  - On a grant to i: rr_ptr <= (i+1) mod NUM_REQ, and push {id=i, len} to the tag queue.
  - With no grant, rr_ptr holds.
  - At most one request is issued per cycle.
- Length decode: len = bits [DATA_WIDTH-1 -: LEN_W].
  - 0 is clamped to 1; values greater than MAX_WORDS are clamped to MAX_WORDS.
  - The request word is forwarded unclamped.
- Tag queue:
  - Circular buffer of TAG_DEPTH entries, pointers wrap modulo TAG_DEPTH.
  - Full means occupancy == TAG_DEPTH. A push is refused when full, even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle leave occupancy unchanged.
  - outstanding = occupancy.
- Response side (zero latency, pass-through):
  - With the head entry {hid, hlen}: when the tag queue is non-empty and !read_fifo_rdempty, rsp_valid[hid]=1 and all other bits are 0.
  - rsp_last = (beat_cnt == hlen-1).
  - read_fifo_deq = rsp_valid[hid] && rsp_ready[hid].
  - rsp_ready bits of non-head requesters are ignored.
  - On a dequeue: if rsp_last, pop the tag queue and set beat_cnt <= 0; otherwise beat_cnt <= beat_cnt+1.
- Ordering: results are delivered strictly in issue order; the CPU returns bursts in request order.
- Orphan data: if the tag queue is empty and !read_fifo_rdempty, do not dequeue and set err_orphan <= 1. It stays set until rst.
- Issue and response sides operate independently in the same cycle. An issue into an empty tag queue is not visible to the response side until the next cycle.

Test Plan:
- Single request: req_valid=0001, req_data[0]=0x3000_0010 (len 3), read FIFO then supplies 0xA,0xB,0xC, rsp_ready=1 -> req_fifo_enq pulses once with 0x3000_0010; rsp_valid=0001 for 3 dequeues; rsp_last=1 on 0xC only; outstanding 1->0.
- Round-robin fairness: req_valid=1111 held, each requester len 1, read FIFO drained continuously -> grant order 0,1,2,3,0,1,...; no requester is granted twice before all others are granted once.
- Backpressure: req_fifo_wrfull=1 for 5 cycles with req_valid=0110 -> req_ready=0 and rr_ptr unchanged; on release, requester 1 is granted first (rr_ptr=0). Separately, issue 4 requests without responses -> outstanding=4 and a 5th request is stalled until a tag is popped.
- Response stall and steering: two outstanding requests, id2 len 2 then id0 len 1; rsp_ready[2]=0 for 3 cycles -> read_fifo_deq=0 throughout; rsp_ready[0]=1 is ignored; after release, words go to id2 then id0.
- Length clamp: len fields 0x0 and 0xF with MAX_WORDS=8 -> 1 and 8 words delivered respectively, with rsp_last on the final word; request words are forwarded unmodified.
- Orphan and reset: read FIFO non-empty with outstanding=0 -> err_orphan=1 and read_fifo_deq stays 0. rst asserted mid-burst -> next cycle all outputs 0, outstanding=0, err_orphan=0.
